// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module   : fifo
// Brief    : Single-clock FIFO, one push or pop per enabled edge (rnw selects).
// Revision : 1.0 - initial release
// ============================================================================
module fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  rnw,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] c_FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic [DATA_WIDTH-1:0] out_q,    out_d;

    logic w_push;
    logic w_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == c_FULL_COUNT);
    assign out   = out_q;

    // Requests against a full/empty queue are silently dropped.
    assign w_push = enable &&  rnw && !full;
    assign w_pop  = enable && !rnw && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            count_d  = count_q + (ADDR_WIDTH+1)'(1);
        end else if (w_pop) begin
            out_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            count_d  = count_q - (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
        end
    end

    // Storage is intentionally not reset; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo
// Brief    : Self-checking bench for fifo: vector table, corner sequences, random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo;

    localparam int c_DW    = 4;
    localparam int c_DEPTH = 8;

    logic            clk;
    logic            rst;
    logic            enable;
    logic            rnw;
    logic [c_DW-1:0] din;
    logic [c_DW-1:0] dout;
    logic            full;
    logic            empty;
    logic            clk_run;

    int n_cmp;
    int n_err;

    logic [c_DW-1:0] model_q[$];
    logic [c_DW-1:0] model_out;

    typedef struct {
        logic            en;
        logic            rnw;
        logic [c_DW-1:0] din;
        logic [c_DW-1:0] exp_out;
        logic            exp_full;
        logic            exp_empty;
    } vec_t;

    vec_t vecs[36];

    fifo #(
        .DATA_WIDTH(c_DW),
        .DEPTH     (c_DEPTH),
        .ADDR_WIDTH(3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .rnw   (rnw),
        .in    (din),
        .out   (dout),
        .full  (full),
        .empty (empty)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_out = '0;
    endtask

    // Drive one operation mid-cycle, let one rising edge act on it, update the model.
    task automatic apply(input logic e, input logic r, input logic [c_DW-1:0] d);
        @(negedge clk);
        enable = e;
        rnw    = r;
        din    = d;
        @(posedge clk);
        #1;
        if (e && r && model_q.size() < c_DEPTH) model_q.push_back(d);
        else if (e && !r && model_q.size() > 0) model_out = model_q.pop_front();
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out"},   32'(dout),  32'(model_out));
        check({tag, ".full"},  32'(full),  32'(model_q.size() == c_DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    endtask

    task automatic op(input logic e, input logic r, input logic [c_DW-1:0] d, input string tag);
        apply(e, r, d);
        check_model(tag);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        clk_run = 1'b0;
        enable  = 1'b0;
        rnw     = 1'b0;
        din     = '0;
        model_reset();

        // Push 0..7, pop 0..7, refill, push-while-full, drain, pop-while-empty, idle.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 1'b1, 4'(i), 4'h0, (i == 7), 1'b0};
        for (int i = 0; i < 8; i++)
            vecs[8+i] = '{1'b1, 1'b0, 4'h0, 4'(i), 1'b0, (i == 7)};
        for (int i = 0; i < 8; i++)
            vecs[16+i] = '{1'b1, 1'b1, 4'(i), 4'h7, (i == 7), 1'b0};
        vecs[24] = '{1'b1, 1'b1, 4'hF, 4'h7, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++)
            vecs[25+i] = '{1'b1, 1'b0, 4'h0, 4'(i), 1'b0, (i == 7)};
        vecs[33] = '{1'b1, 1'b0, 4'h0, 4'h7, 1'b0, 1'b1};
        vecs[34] = '{1'b0, 1'b1, 4'h9, 4'h7, 1'b0, 1'b1};
        vecs[35] = '{1'b0, 1'b0, 4'h3, 4'h7, 1'b0, 1'b1};

        // Asynchronous reset with no clock running.
        rst = 1'b1;
        #1;
        check("rst.out",   32'(dout),  32'h0);
        check("rst.empty", 32'(empty), 32'h1);
        check("rst.full",  32'(full),  32'h0);
        #2;
        rst = 1'b0;
        clk_run = 1'b1;

        for (int i = 0; i < 36; i++) begin
            apply(vecs[i].en, vecs[i].rnw, vecs[i].din);
            check($sformatf("vec%0d.out", i),   32'(dout),  32'(vecs[i].exp_out));
            check($sformatf("vec%0d.full", i),  32'(full),  32'(vecs[i].exp_full));
            check($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].exp_empty));
        end

        // Pointer wrap: offset the pointers by 5, then fill and drain completely.
        for (int i = 0; i < 5; i++) op(1'b1, 1'b1, 4'(i + 1), "wrap.pre_push");
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 4'h0,      "wrap.pre_pop");
        for (int i = 0; i < 8; i++) op(1'b1, 1'b1, 4'(8 + i), "wrap.push");
        check("wrap.full_after_8", 32'(full), 32'h1);
        for (int i = 0; i < 4; i++) op(1'b0, 1'(i), 4'(i * 3), "wrap.idle");
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b0, 4'h0);
            check("wrap.order", 32'(dout), 32'(8 + i));
        end
        check("wrap.empty_after_8", 32'(empty), 32'h1);

        // Reset asserted between edges after three pushes discards everything.
        for (int i = 0; i < 3; i++) op(1'b1, 1'b1, 4'(i + 4), "midrst.push");
        op(1'b1, 1'b0, 4'h0, "midrst.pop");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("midrst");
        @(negedge clk);
        rst = 1'b0;
        op(1'b1, 1'b0, 4'h0, "midrst.pop_empty");

        // Randomised traffic biased so the queue visits both full and empty.
        for (int i = 0; i < 600; i++) begin
            logic e, r;
            e = ($urandom_range(0, 9) != 0);
            r = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            op(e, r, 4'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
